sub_serial_digit: RTL and testbench

//  Digit-serial WIDTH-bit two's-complement subtractor: the inverse datapath companion of the crypto-benchmark ripple adders.

---
 rtl/sub_serial_pkg.sv | 19 +
 rtl/sub_digit.sv | 25 ++
 rtl/sub_serial_digit.sv | 139 +++++++++++++
 tb/tb_sub_serial_digit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sub_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned n_digits(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // Counter needs at least one bit even when a single digit covers the word.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit subtract slice: ripple of full-subtractor cells.
module sub_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] brw;

    always_comb begin
        brw    = '0;
        d      = '0;
        brw[0] = bin;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            d[i]     = a[i] ^ b[i] ^ brw[i];
            brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
        end
        bout = brw[DIGIT];
    end

endmodule

// File: rtl/sub_serial_digit.sv
// Digit-serial two's-complement subtractor, LSB digit first, registered borrow chain.
// Optional SUB_SERIAL_SAT_EN: unsigned saturation of out_diff to zero on borrow-out.
module sub_serial_digit
    import sub_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_bout,
    output logic             out_ovf
);

    localparam int unsigned N  = n_digits(WIDTH, DIGIT);
    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH % DIGIT != 0) begin : g_width_check
        $error("sub_serial_digit: WIDTH must be a multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_d;
    logic             dig_bout;

    sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .bin  (brw_q),
        .d    (dig_d),
        .bout (dig_bout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    brw_d   = in_bin;
                    amsb_d  = in_a[WIDTH-1];
                    bmsb_d  = in_b[WIDTH-1];
                    cnt_d   = '0;
                    diff_d  = '0;
                    bout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d    = a_q >> DIGIT;
                b_d    = b_q >> DIGIT;
                // New digit enters at the MSB end; written as a wide shift so DIGIT==WIDTH stays legal.
                diff_d = WIDTH'({dig_d, diff_q} >> DIGIT);
                brw_d  = dig_bout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    bout_d  = dig_bout;
                    ovf_d   = (amsb_q != bmsb_q) && (dig_d[DIGIT-1] != amsb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bout  = bout_q;
    assign out_ovf   = ovf_q;

`ifdef SUB_SERIAL_SAT_EN
    assign out_diff = bout_q ? '0 : diff_q;
`else
    assign out_diff = diff_q;
`endif

endmodule

// File: tb/tb_sub_serial_digit.sv
// Self-checking bench for sub_serial_digit: directed corners plus randomized operands vs. an arithmetic model.
module tb_sub_serial_digit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DIGIT = 4;
    localparam int unsigned N     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_bout;
    logic             out_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    sub_serial_digit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_bout  (out_bout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole word.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                         output logic [31:0] d, output logic bo, output logic ov);
        longint sd;
        longint unsigned ua, ub;
        ua = {32'd0, a};
        ub = {32'd0, b} + {63'd0, bin};
        sd = longint'($signed(a)) - longint'($signed(b)) - longint'({63'd0, bin});
        bo = (ua < ub);
        ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        d  = a - b - {31'd0, bin};
`ifdef SUB_SERIAL_SAT_EN
        if (bo) d = '0;
`endif
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin, input int stall);
        logic [31:0] ed;
        logic        eb, eo;
        int          guard;
        int          lat;
        model(a, b, bin, ed, eb, eo);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("accept_wait", 64'(guard), 64'd0);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_bin   = bin;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_bin   = 1'($urandom);
        check_eq("in_ready_run", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 4 * N) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(N));
        check_eq("diff", 64'(out_diff), 64'(ed));
        check_eq("bout", 64'(out_bout), 64'(eb));
        check_eq("ovf", 64'(out_ovf), 64'(eo));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_diff", 64'(out_diff), 64'(ed));
            check_eq("hold_flags", {62'd0, out_bout, out_ovf}, {62'd0, eb, eo});
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("valid_drop", 64'(out_valid), 64'd0);
        check_eq("idle_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] corners [6];
        logic [31:0] ra, rb;
        int          seen;
        corners[0] = 32'h0000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'h7FFF_FFFF;
        corners[4] = 32'h0000_0001;
        corners[5] = 32'h8000_0001;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_bin    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out", {31'd0, out_diff, out_bout, out_ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'd5, 32'd3, 1'b0, 0);
        run_op(32'd0, 32'd1, 1'b0, 0);
        run_op(32'h8000_0000, 32'd1, 1'b0, 1);
        run_op(32'h10, 32'h0F, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 5);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);

        // Abort mid-RUN with reset: no result may surface.
        in_valid = 1'b1;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'h0123_4567;
        in_bin   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", 64'(out_valid), 64'd0);
        check_eq("abort_ready", 64'(in_ready), 64'd1);
        check_eq("abort_out", {31'd0, out_diff, out_bout, out_ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        check_eq("abort_no_result", 64'(seen), 64'd0);
        run_op(32'd7, 32'd2, 1'b0, 0);

        for (int k = 0; k < 60; k++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
